// File: rtl/jttrack_sndlatch.sv
// jttrack_sndlatch
// Bridge from the Track'n Field main CPU to the sound CPU. It holds the 8-bit
// sound command latch and drives the sound IRQ, which is cleared by an ack or,
// optionally, by a timeout. It also provides the free-running sound timer nibble
// and a saturating count of command overwrites. Everything runs on the 24 MHz clk.
//
// Ports
//   clk        in   system clock (24 MHz)
//   rst_n      in   asynchronous active-low reset
//   snd_cen    in   sound CPU clock enable
//   main_dout  in   [7:0] main CPU data bus
//   m2s_data   in   latch write select (level, rising edge = write)
//   m2s_irq    in   sound IRQ trigger (level, rising edge = trigger)
//   latch_rd   in   one-clk pulse, sound CPU reads the latch
//   irq_ack    in   one-clk pulse, sound CPU interrupt acknowledge
//   snd_dout   out  [7:0] latch contents
//   timer_dout out  [3:0] timer nibble
//   int_n      out  sound IRQ, active low
//   latch_full out  latch written and not yet read
//   ovr_cnt    out  [7:0] saturating count of unread-data overwrites

module jttrack_sndlatch #(
    parameter int TIMER_W  = 14,
    parameter int TIMER_SH = 10,
    parameter int IRQ_HOLD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       snd_cen,
    input  logic [7:0] main_dout,
    input  logic       m2s_data,
    input  logic       m2s_irq,
    input  logic       latch_rd,
    input  logic       irq_ack,
    output logic [7:0] snd_dout,
    output logic [3:0] timer_dout,
    output logic       int_n,
    output logic       latch_full,
    output logic [7:0] ovr_cnt
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ASSERT = 1'b1;

    // The hold counter only has to reach IRQ_HOLD-1.
    localparam int HOLD_W = (IRQ_HOLD > 1) ? $clog2(IRQ_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = (IRQ_HOLD > 0) ? HOLD_W'(IRQ_HOLD - 1) : '0;

    // ---------------------------------------------------------------
    // Edge detection
    // ---------------------------------------------------------------
    // The data strobe is edge-detected directly against its delayed copy, so a
    // write lands on the first clk that sees m2s_data high. The IRQ trigger goes
    // through an extra sync register first. This gives int_n two clks of latency
    // from the raw rise: sync register, then state register.
    logic r_data_q;
    logic r_irq_s;
    logic r_irq_q;
    logic w_data_ev;
    logic w_irq_ev;

    assign w_data_ev = m2s_data & ~r_data_q;
    assign w_irq_ev  = r_irq_s  & ~r_irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_q <= 1'b0;
            r_irq_s  <= 1'b0;
            r_irq_q  <= 1'b0;
        end else begin
            r_data_q <= m2s_data;
            r_irq_s  <= m2s_irq;
            r_irq_q  <= r_irq_s;
        end
    end

    // ---------------------------------------------------------------
    // Command latch
    // ---------------------------------------------------------------
    logic [7:0] r_dout;
    logic       r_full;
    logic [7:0] r_ovr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= 8'h00;
            r_full <= 1'b0;
            r_ovr  <= 8'h00;
        end else if (w_data_ev) begin
            // A read in the same cycle consumes the old value. The new one is
            // then still unread, and nothing was lost.
            r_dout <= main_dout;
            r_full <= 1'b1;
            if (r_full && !latch_rd && r_ovr != 8'hFF)
                r_ovr <= r_ovr + 8'd1;
        end else if (latch_rd) begin
            r_full <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // IRQ FSM with optional auto-clear
    // ---------------------------------------------------------------
    logic [0:0]        r_state;
    logic [HOLD_W-1:0] r_hold;
    logic              w_timeout;

    assign w_timeout = (IRQ_HOLD != 0) && snd_cen && (r_hold == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_irq_ev) begin
                        r_state <= ST_ASSERT;
                        r_hold  <= '0;
                    end
                end
                default: begin
                    // A new trigger takes priority over ack and timeout. It
                    // re-arms the hold window.
                    if (w_irq_ev)
                        r_hold <= '0;
                    else if (irq_ack || w_timeout)
                        r_state <= ST_IDLE;
                    else if (snd_cen)
                        r_hold <= r_hold + 1'b1;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Free-running sound timer
    // ---------------------------------------------------------------
    logic [TIMER_W-1:0] r_timer_cnt;
    logic [3:0]         r_timer_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer_cnt  <= '0;
            r_timer_dout <= 4'h0;
        end else begin
            if (snd_cen)
                r_timer_cnt <= r_timer_cnt + 1'b1;
            r_timer_dout <= r_timer_cnt[TIMER_SH+3:TIMER_SH];
        end
    end

    assign snd_dout   = r_dout;
    assign latch_full = r_full;
    assign ovr_cnt    = r_ovr;
    assign int_n      = (r_state != ST_ASSERT);
    assign timer_dout = r_timer_dout;

endmodule

// File: tb/tb_jttrack_sndlatch.sv
module tb_jttrack_sndlatch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       snd_cen = 1'b0;
    logic [7:0] main_dout = 8'h00;
    logic       m2s_data = 1'b0;
    logic       m2s_irq = 1'b0;
    logic       latch_rd = 1'b0;
    logic       irq_ack = 1'b0;

    logic [7:0] snd_dout, ovr_cnt, snd_dout_h, ovr_cnt_h;
    logic [3:0] timer_dout, timer_dout_h;
    logic       int_n, latch_full, int_n_h, latch_full_h;

    int n_cmp = 0;
    int n_err = 0;

    jttrack_sndlatch dut (
        .clk(clk), .rst_n(rst_n), .snd_cen(snd_cen), .main_dout(main_dout),
        .m2s_data(m2s_data), .m2s_irq(m2s_irq), .latch_rd(latch_rd), .irq_ack(irq_ack),
        .snd_dout(snd_dout), .timer_dout(timer_dout), .int_n(int_n),
        .latch_full(latch_full), .ovr_cnt(ovr_cnt)
    );

    jttrack_sndlatch #(.IRQ_HOLD(4)) dut_h (
        .clk(clk), .rst_n(rst_n), .snd_cen(snd_cen), .main_dout(main_dout),
        .m2s_data(m2s_data), .m2s_irq(m2s_irq), .latch_rd(latch_rd), .irq_ack(irq_ack),
        .snd_dout(snd_dout_h), .timer_dout(timer_dout_h), .int_n(int_n_h),
        .latch_full(latch_full_h), .ovr_cnt(ovr_cnt_h)
    );

    always #5 clk = ~clk;

    // Reference model, updated once per rising edge from the inputs applied before it.
    int m_dout, m_ovr, m_pulses, m_tdout, m_since;
    bit m_full, m_data_prev, m_irq_prev, m_ev_pending, m_as, m_ah;

    task model_reset();
        m_dout = 0; m_ovr = 0; m_pulses = 0; m_tdout = 0; m_since = 0;
        m_full = 0; m_data_prev = 0; m_irq_prev = 0; m_ev_pending = 0; m_as = 0; m_ah = 0;
    endtask

    task model_step();
        bit wev;
        if (!rst_n) begin
            model_reset();
            return;
        end
        wev = m2s_data && !m_data_prev;
        m_data_prev = m2s_data;
        if (wev) begin
            if (m_full && !latch_rd && m_ovr < 255) m_ovr++;
            m_dout = main_dout;
            m_full = 1;
        end else if (latch_rd) begin
            m_full = 0;
        end
        // A trigger reaches the IRQ one clk after its rising level is seen.
        if (m_ev_pending) begin
            m_as = 1; m_ah = 1; m_since = 0;
        end else begin
            if (irq_ack) m_as = 0;
            if (m_ah) begin
                if (irq_ack) m_ah = 0;
                else if (snd_cen) begin
                    m_since++;
                    if (m_since == 4) m_ah = 0;
                end
            end
        end
        m_ev_pending = m2s_irq && !m_irq_prev;
        m_irq_prev = m2s_irq;
        m_tdout = (m_pulses >> 10) & 15;
        if (snd_cen) m_pulses = (m_pulses + 1) % 16384;
    endtask

    task tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task test_reset();
        model_reset();
        #2;
        n_cmp++;
        if ({snd_dout, timer_dout, int_n, latch_full, ovr_cnt} !== {8'h00, 4'h0, 1'b1, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL reset_state got dout=%h tmr=%h int_n=%b full=%b ovr=%h want 00 0 1 0 00",
                     snd_dout, timer_dout, int_n, latch_full, ovr_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
    endtask

    task test_latch_write_read();
        main_dout = 8'hA5; m2s_data = 1'b1;
        tick();
        m2s_data = 1'b0;
        n_cmp++;
        if (snd_dout !== 8'hA5 || latch_full !== 1'b1) begin
            n_err++;
            $display("FAIL write_a5 got dout=%h full=%b want a5 1", snd_dout, latch_full);
        end
        latch_rd = 1'b1;
        tick();
        latch_rd = 1'b0;
        n_cmp++;
        if (latch_full !== 1'b0 || ovr_cnt !== 8'h00) begin
            n_err++;
            $display("FAIL read_clear got full=%b ovr=%h want 0 00", latch_full, ovr_cnt);
        end
    endtask

    task test_overrun();
        for (int i = 1; i <= 3; i++) begin
            main_dout = 8'(i); m2s_data = 1'b1;
            tick();
            m2s_data = 1'b0;
            tick();
        end
        n_cmp++;
        if (snd_dout !== 8'h03 || ovr_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL overrun3 got dout=%h ovr=%0d want 03 2", snd_dout, ovr_cnt);
        end
        main_dout = 8'h44; m2s_data = 1'b1; latch_rd = 1'b1;
        tick();
        m2s_data = 1'b0; latch_rd = 1'b0;
        n_cmp++;
        if (latch_full !== 1'b1 || ovr_cnt !== 8'd2 || snd_dout !== 8'h44) begin
            n_err++;
            $display("FAIL write_read_same got full=%b ovr=%0d dout=%h want 1 2 44", latch_full, ovr_cnt, snd_dout);
        end
        latch_rd = 1'b1;
        tick();
        latch_rd = 1'b0;
    endtask

    task test_irq_latency();
        m2s_irq = 1'b1;
        tick();
        n_cmp++;
        if (int_n !== 1'b1) begin
            n_err++;
            $display("FAIL irq_lat1 got int_n=%b want 1", int_n);
        end
        tick();
        n_cmp++;
        if (int_n !== 1'b0) begin
            n_err++;
            $display("FAIL irq_lat2 got int_n=%b want 0", int_n);
        end
        m2s_irq = 1'b0; irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        n_cmp++;
        if (int_n !== 1'b1) begin
            n_err++;
            $display("FAIL irq_ack got int_n=%b want 1", int_n);
        end
    endtask

    task test_irq_level_hold();
        int  n_as;
        logic prev;
        n_as = 0;
        prev = int_n;
        m2s_irq = 1'b1;
        for (int i = 0; i < 100; i++) begin
            irq_ack = (int_n === 1'b0);
            tick();
            if (prev === 1'b1 && int_n === 1'b0) n_as++;
            prev = int_n;
        end
        irq_ack = 1'b0; m2s_irq = 1'b0;
        tick();
        n_cmp++;
        if (n_as != 1 || int_n !== 1'b1) begin
            n_err++;
            $display("FAIL irq_level_once got assertions=%0d int_n=%b want 1 1", n_as, int_n);
        end
    endtask

    task pulse_cen();
        snd_cen = 1'b1;
        tick();
        snd_cen = 1'b0;
        tick();
    endtask

    task test_irq_hold_timeout();
        m2s_irq = 1'b1; tick();
        m2s_irq = 1'b0; tick();
        for (int p = 1; p <= 3; p++) begin
            pulse_cen();
            n_cmp++;
            if (int_n_h !== 1'b0) begin
                n_err++;
                $display("FAIL hold_pulse%0d got int_n=%b want 0", p, int_n_h);
            end
        end
        snd_cen = 1'b1; tick(); snd_cen = 1'b0;
        n_cmp++;
        if (int_n_h !== 1'b1) begin
            n_err++;
            $display("FAIL hold_timeout got int_n=%b want 1", int_n_h);
        end
        tick();
        // Re-trigger so the new event coincides with the third snd_cen.
        m2s_irq = 1'b1; tick();
        m2s_irq = 1'b0; tick();
        pulse_cen();
        pulse_cen();
        m2s_irq = 1'b1; tick();
        m2s_irq = 1'b0; snd_cen = 1'b1; tick();
        snd_cen = 1'b0; tick();
        for (int p = 1; p <= 3; p++) begin
            pulse_cen();
            n_cmp++;
            if (int_n_h !== 1'b0) begin
                n_err++;
                $display("FAIL hold_restart%0d got int_n=%b want 0", p, int_n_h);
            end
        end
        snd_cen = 1'b1; tick(); snd_cen = 1'b0;
        n_cmp++;
        if (int_n_h !== 1'b1) begin
            n_err++;
            $display("FAIL hold_restart_timeout got int_n=%b want 1", int_n_h);
        end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        n_cmp++;
        if (int_n !== 1'b1) begin
            n_err++;
            $display("FAIL default_ack got int_n=%b want 1", int_n);
        end
    endtask

    task test_random();
        for (int i = 0; i < 3000; i++) begin
            main_dout = 8'($urandom);
            m2s_data  = ($urandom % 3 == 0);
            m2s_irq   = ($urandom % 3 == 0);
            latch_rd  = ($urandom % 5 == 0);
            irq_ack   = ($urandom % 6 == 0);
            snd_cen   = ($urandom % 2 == 1);
            tick();
            n_cmp++;
            if (snd_dout !== 8'(m_dout) || latch_full !== m_full || ovr_cnt !== 8'(m_ovr)) begin
                n_err++;
                if (n_err < 30)
                    $display("FAIL rnd_latch cyc=%0d got %h/%b/%0d want %h/%b/%0d",
                             i, snd_dout, latch_full, ovr_cnt, m_dout, m_full, m_ovr);
            end
            n_cmp++;
            if (int_n !== !m_as || int_n_h !== !m_ah) begin
                n_err++;
                if (n_err < 30)
                    $display("FAIL rnd_irq cyc=%0d got %b/%b want %b/%b", i, int_n, int_n_h, !m_as, !m_ah);
            end
            n_cmp++;
            if (timer_dout !== 4'(m_tdout)) begin
                n_err++;
                if (n_err < 30)
                    $display("FAIL rnd_timer cyc=%0d got %h want %h", i, timer_dout, m_tdout);
            end
        end
        m2s_data = 1'b0; m2s_irq = 1'b0; latch_rd = 1'b0; irq_ack = 1'b0; snd_cen = 1'b0;
        tick();
        tick();
    endtask

    task test_reset_mid();
        main_dout = 8'h5A; m2s_data = 1'b1; m2s_irq = 1'b1;
        tick();
        m2s_data = 1'b0;
        tick();
        m2s_irq = 1'b0;
        n_cmp++;
        if (int_n !== 1'b0 || latch_full !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset got int_n=%b full=%b want 0 1", int_n, latch_full);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (int_n !== 1'b1) begin
            n_err++;
            $display("FAIL async_int_n got int_n=%b want 1", int_n);
        end
        tick();
        n_cmp++;
        if ({snd_dout, timer_dout, int_n, latch_full, ovr_cnt} !== {8'h00, 4'h0, 1'b1, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL mid_reset got dout=%h tmr=%h int_n=%b full=%b ovr=%h want 00 0 1 0 00",
                     snd_dout, timer_dout, int_n, latch_full, ovr_cnt);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task test_timer();
        int exp;
        for (int k = 1; k <= 16384; k++) begin
            pulse_cen();
            exp = (k >> 10) & 15;
            n_cmp++;
            if (timer_dout !== 4'(exp)) begin
                n_err++;
                if (n_err < 30)
                    $display("FAIL timer k=%0d got %h want %h", k, timer_dout, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latch_write_read();
        test_overrun();
        test_irq_latency();
        test_irq_level_hold();
        test_irq_hold_timeout();
        test_random();
        test_reset_mid();
        test_timer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
